// File: rtl/uart_axil_sequencer.sv
// -----------------------------------------------------------------------------
// uart_axil_sequencer
//
// AXI4-Lite master that programs the UART register slave and then streams
// bytes into it. A cfg_start request writes LCR, FCR and IER in that order.
// After that, each byte accepted on the tx valid/ready port is sent as:
// LSR polls until the TX FIFO is not full, a write to TDR, and (optionally)
// a write that pulses the OCR start bit.
//
// Compile-time option:
//   UART_SEQ_OCR_KICK_EN - when defined, every TDR write is followed by an
//                          OCR start-bit write. When undefined, the OCR state
//                          and its logic are removed and no OCR access is made.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_cfg_start           one-cycle request to (re)program LCR/FCR/IER
//   i_cfg_lcr/fcr/ier     configuration values, sampled when cfg_start is taken
//   i_tx_data/i_tx_valid  byte source; o_tx_ready accepts the byte
//   o_cfg_done            high while configured (READY/POLL/WR_TDR/WR_OCR)
//   o_busy                high in every state except IDLE and READY
//   o_err                 sticky error: bad bresp/rresp or LSR poll timeout
//   *_m_axi_*             AXI4-Lite master (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
package common_pkg;
    localparam logic [31:0] ADDR_TDR = 32'h0000_0000;
    localparam logic [31:0] ADDR_IER = 32'h0000_0004;
    localparam logic [31:0] ADDR_FCR = 32'h0000_0008;
    localparam logic [31:0] ADDR_LCR = 32'h0000_000C;
    localparam logic [31:0] ADDR_OCR = 32'h0000_0010;
    localparam logic [31:0] ADDR_LSR = 32'h0000_0014;
endpackage

module uart_axil_sequencer #(
    parameter int TX_FULL_BIT = 1,
    parameter int POLL_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cfg_start,
    input  logic [31:0] i_cfg_lcr,
    input  logic [31:0] i_cfg_fcr,
    input  logic [31:0] i_cfg_ier,
    input  logic [7:0]  i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    output logic        o_cfg_done,
    output logic        o_busy,
    output logic        o_err,
    output logic [31:0] o_m_axi_awaddr,
    output logic        o_m_axi_awvalid,
    input  logic        i_m_axi_awready,
    output logic [31:0] o_m_axi_wdata,
    output logic [3:0]  o_m_axi_wstrb,
    output logic        o_m_axi_wvalid,
    input  logic        i_m_axi_wready,
    input  logic [1:0]  i_m_axi_bresp,
    input  logic        i_m_axi_bvalid,
    output logic        o_m_axi_bready,
    output logic [31:0] o_m_axi_araddr,
    output logic        o_m_axi_arvalid,
    input  logic        i_m_axi_arready,
    input  logic [31:0] i_m_axi_rdata,
    input  logic [1:0]  i_m_axi_rresp,
    input  logic        i_m_axi_rvalid,
    output logic        o_m_axi_rready
);
    import common_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG_LCR = 3'd1,
        S_CFG_FCR = 3'd2,
        S_CFG_IER = 3'd3,
        S_READY   = 3'd4,
        S_POLL    = 3'd5,
        S_WR_TDR  = 3'd6
`ifdef UART_SEQ_OCR_KICK_EN
        , S_WR_OCR = 3'd7
`endif
    } state_t;

    localparam logic [16:0] LP_LIMIT = 17'(POLL_LIMIT);

    state_t      r_state, w_state_nxt;
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_err;
    logic        r_cfg_done, r_busy;
    logic [31:0] r_awaddr, r_wdata, r_araddr, r_fcr, r_ier;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_byte;
    logic [15:0] r_poll_cnt;

    logic        w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;
    logic        w_err_nxt, w_cfg_done_nxt, w_busy_nxt, w_issue, w_wr_go, w_rd_go;
    logic [31:0] w_awaddr_nxt, w_wdata_nxt, w_araddr_nxt, w_fcr_nxt, w_ier_nxt;
    logic [3:0]  w_wstrb_nxt;
    logic [7:0]  w_byte_nxt;
    logic [15:0] w_poll_cnt_nxt;

    // Handshake/event decode shared by next-state and output logic
    logic w_wr_done, w_rd_done, w_cfg_acc, w_tx_acc, w_rd_full, w_timeout, w_unused;
    assign w_wr_done = r_bready & i_m_axi_bvalid;
    assign w_rd_done = r_rready & i_m_axi_rvalid;
    assign w_cfg_acc = i_cfg_start & ((r_state == S_IDLE) | (r_state == S_READY));
    assign w_tx_acc  = i_tx_valid & o_tx_ready;
    // A failed LSR read cannot be trusted, so it counts as "full"
    assign w_rd_full = i_m_axi_rdata[TX_FULL_BIT] | (i_m_axi_rresp != 2'b00);
    assign w_timeout = w_rd_done & w_rd_full & (({1'b0, r_poll_cnt} + 17'd1) >= LP_LIMIT);
    assign w_unused  = ^i_m_axi_rdata;

    assign o_tx_ready      = (r_state == S_READY) & ~i_cfg_start;
    assign o_cfg_done      = r_cfg_done;
    assign o_busy          = r_busy;
    assign o_err           = r_err;
    assign o_m_axi_awaddr  = r_awaddr;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = r_wstrb;
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_bready  = r_bready;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = r_rready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    w_state_nxt = i_cfg_start ? S_CFG_LCR : S_IDLE;
            S_CFG_LCR: w_state_nxt = w_wr_done ? S_CFG_FCR : S_CFG_LCR;
            S_CFG_FCR: w_state_nxt = w_wr_done ? S_CFG_IER : S_CFG_FCR;
            S_CFG_IER: w_state_nxt = w_wr_done ? S_READY : S_CFG_IER;
            S_READY: begin
                if (i_cfg_start) begin
                    w_state_nxt = S_CFG_LCR;
                end else if (i_tx_valid) begin
                    w_state_nxt = S_POLL;
                end else begin
                    w_state_nxt = S_READY;
                end
            end
            S_POLL: begin
                if (!w_rd_done) begin
                    w_state_nxt = S_POLL;
                end else if (!w_rd_full) begin
                    w_state_nxt = S_WR_TDR;
                end else if (w_timeout) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_state_nxt = S_POLL;
                end
            end
`ifdef UART_SEQ_OCR_KICK_EN
            S_WR_TDR:  w_state_nxt = w_wr_done ? S_WR_OCR : S_WR_TDR;
            S_WR_OCR:  w_state_nxt = w_wr_done ? S_READY : S_WR_OCR;
`else
            S_WR_TDR:  w_state_nxt = w_wr_done ? S_READY : S_WR_TDR;
`endif
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of all registered outputs and datapath
    always_comb begin
        // Each valid/ready drops independently on its own handshake
        w_awvalid_nxt  = r_awvalid & ~i_m_axi_awready;
        w_wvalid_nxt   = r_wvalid & ~i_m_axi_wready;
        w_bready_nxt   = r_bready & ~i_m_axi_bvalid;
        w_arvalid_nxt  = r_arvalid & ~i_m_axi_arready;
        w_rready_nxt   = r_rready & ~i_m_axi_rvalid;
        w_awaddr_nxt   = r_awaddr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_araddr_nxt   = r_araddr;
        w_fcr_nxt      = w_cfg_acc ? i_cfg_fcr : r_fcr;
        w_ier_nxt      = w_cfg_acc ? i_cfg_ier : r_ier;
        w_byte_nxt     = w_tx_acc ? i_tx_data : r_byte;
        w_wr_go        = 1'b0;
        w_rd_go        = 1'b0;
        w_cfg_done_nxt = (w_state_nxt == S_READY) | (w_state_nxt == S_POLL) |
                         (w_state_nxt == S_WR_TDR)
`ifdef UART_SEQ_OCR_KICK_EN
                         | (w_state_nxt == S_WR_OCR)
`endif
                         ;
        w_busy_nxt     = (w_state_nxt != S_IDLE) & (w_state_nxt != S_READY);

        if (w_cfg_acc) begin
            w_err_nxt = 1'b0;
        end else if ((w_wr_done & (i_m_axi_bresp != 2'b00)) |
                     (w_rd_done & (i_m_axi_rresp != 2'b00)) | w_timeout) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err;
        end

        if ((w_state_nxt == S_POLL) && (r_state != S_POLL)) begin
            w_poll_cnt_nxt = 16'd0;
        end else if (w_rd_done && w_rd_full) begin
            w_poll_cnt_nxt = r_poll_cnt + 16'd1;
        end else begin
            w_poll_cnt_nxt = r_poll_cnt;
        end

        // A new transaction starts on every state entry, and on every
        // repeated LSR read while staying in POLL
        w_issue = (w_state_nxt != r_state) | w_rd_done;
        if (w_issue) begin
            case (w_state_nxt)
                S_CFG_LCR: begin
                    w_wr_go = 1'b1; w_awaddr_nxt = ADDR_LCR;
                    w_wdata_nxt = i_cfg_lcr; w_wstrb_nxt = 4'hF;
                end
                S_CFG_FCR: begin
                    w_wr_go = 1'b1; w_awaddr_nxt = ADDR_FCR;
                    w_wdata_nxt = r_fcr; w_wstrb_nxt = 4'hF;
                end
                S_CFG_IER: begin
                    w_wr_go = 1'b1; w_awaddr_nxt = ADDR_IER;
                    w_wdata_nxt = r_ier; w_wstrb_nxt = 4'hF;
                end
                S_POLL: begin
                    w_rd_go = 1'b1; w_araddr_nxt = ADDR_LSR;
                end
                S_WR_TDR: begin
                    w_wr_go = 1'b1; w_awaddr_nxt = ADDR_TDR;
                    w_wdata_nxt = {24'h00_0000, r_byte}; w_wstrb_nxt = 4'h1;
                end
`ifdef UART_SEQ_OCR_KICK_EN
                S_WR_OCR: begin
                    w_wr_go = 1'b1; w_awaddr_nxt = ADDR_OCR;
                    w_wdata_nxt = 32'h0000_0002; w_wstrb_nxt = 4'h1;
                end
`endif
                default: begin
                    w_wr_go = 1'b0;
                end
            endcase
        end else begin
            w_wr_go = 1'b0;
        end

        // bready goes up with wvalid: the slave needs it while data is offered
        if (w_wr_go) begin
            w_awvalid_nxt = 1'b1; w_wvalid_nxt = 1'b1; w_bready_nxt = 1'b1;
        end else begin
            w_wr_go = 1'b0;
        end
        if (w_rd_go) begin
            w_arvalid_nxt = 1'b1; w_rready_nxt = 1'b1;
        end else begin
            w_rd_go = 1'b0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_awvalid  <= 1'b0;  r_wvalid   <= 1'b0;  r_bready <= 1'b0;
            r_arvalid  <= 1'b0;  r_rready   <= 1'b0;  r_err    <= 1'b0;
            r_cfg_done <= 1'b0;  r_busy     <= 1'b0;
            r_awaddr   <= 32'h0; r_wdata    <= 32'h0; r_wstrb  <= 4'h0;
            r_araddr   <= 32'h0; r_fcr      <= 32'h0; r_ier    <= 32'h0;
            r_byte     <= 8'h00; r_poll_cnt <= 16'd0;
        end else begin
            r_awvalid  <= w_awvalid_nxt;  r_wvalid   <= w_wvalid_nxt;
            r_bready   <= w_bready_nxt;   r_arvalid  <= w_arvalid_nxt;
            r_rready   <= w_rready_nxt;   r_err      <= w_err_nxt;
            r_cfg_done <= w_cfg_done_nxt; r_busy     <= w_busy_nxt;
            r_awaddr   <= w_awaddr_nxt;   r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;    r_araddr   <= w_araddr_nxt;
            r_fcr      <= w_fcr_nxt;      r_ier      <= w_ier_nxt;
            r_byte     <= w_byte_nxt;     r_poll_cnt <= w_poll_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_axil_sequencer.sv
`timescale 1ns/1ps
module tb_uart_axil_sequencer;
    import common_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, cfg_start = 1'b0, tx_valid = 1'b0;
    logic [31:0] cfg_lcr = 32'h0, cfg_fcr = 32'h0, cfg_ier = 32'h0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready, cfg_done, busy, err;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    uart_axil_sequencer #(.TX_FULL_BIT(1), .POLL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_start(cfg_start), .i_cfg_lcr(cfg_lcr), .i_cfg_fcr(cfg_fcr), .i_cfg_ier(cfg_ier),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_cfg_done(cfg_done), .o_busy(busy), .o_err(err),
        .o_m_axi_awaddr(awaddr), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid),
        .i_m_axi_wready(wready),
        .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready),
        .o_m_axi_araddr(araddr), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
        .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rvalid(rvalid),
        .o_m_axi_rready(rready)
    );

    int n_vec = 0, n_err = 0;
    int bready_viol = 0;

    // Single comparison point: counts every vector, reports every miscompare
    task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- slave model and bus log ----------------
    // log entry: {kind(2'b01 write, 2'b10 read), addr, data, strb}
    logic [69:0] obs_q[$], exp_q[$];
    logic [1:0]  bresp_q[$];   // per-write response code, OKAY when empty
    logic [1:0]  lsr_q[$];     // per-LSR-read: [1] rresp error, [0] full bit
    logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic [31:0] aw_addr_q = 32'h0, w_data_q = 32'h0, ar_addr_q = 32'h0;
    logic [3:0]  w_strb_q = 4'h0;
    logic        sn_aw = 1'b0, sn_w = 1'b0, sn_b = 1'b0, sn_ar = 1'b0, sn_r = 1'b0;
    logic [31:0] sn_awaddr = 32'h0, sn_wdata = 32'h0, sn_araddr = 32'h0;
    logic [3:0]  sn_wstrb = 4'h0;

    // Values at a negedge are those the next posedge will see
    initial begin
        logic [1:0]  ent;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
                awready = 1'b0; wready = 1'b0; arready = 1'b0;
                bvalid = 1'b0; rvalid = 1'b0;
            end else begin
                if (sn_aw) begin aw_got = 1'b1; aw_addr_q = sn_awaddr; end
                if (sn_w)  begin w_got = 1'b1; w_data_q = sn_wdata; w_strb_q = sn_wstrb; end
                if (sn_ar) begin ar_got = 1'b1; ar_addr_q = sn_araddr; end
                if (sn_b)  bvalid = 1'b0;
                if (sn_r)  rvalid = 1'b0;
                if (aw_got && w_got && !bvalid && ($urandom_range(0, 2) != 0)) begin
                    if (bresp_q.size() > 0) bresp = bresp_q.pop_front();
                    else bresp = 2'b00;
                    bvalid = 1'b1;
                    obs_q.push_back({2'b01, aw_addr_q, w_data_q, w_strb_q});
                    aw_got = 1'b0; w_got = 1'b0;
                end
                if (ar_got && !rvalid && ($urandom_range(0, 2) != 0)) begin
                    if (lsr_q.size() > 0) ent = lsr_q.pop_front();
                    else ent = 2'b00;
                    rd = $urandom; rd[1] = ent[0];
                    rdata = rd; rresp = ent[1] ? 2'b10 : 2'b00; rvalid = 1'b1;
                    obs_q.push_back({2'b10, ar_addr_q, 32'h0, 4'h0});
                    ar_got = 1'b0;
                end
                awready = !aw_got && ($urandom_range(0, 3) != 0);
                wready  = !w_got && ($urandom_range(0, 3) != 0);
                arready = !ar_got && ($urandom_range(0, 3) != 0);
            end
            if (wvalid && !bready) bready_viol++;
            sn_aw = awvalid & awready; sn_w = wvalid & wready; sn_b = bvalid & bready;
            sn_ar = arvalid & arready; sn_r = rvalid & rready;
            sn_awaddr = awaddr; sn_wdata = wdata; sn_wstrb = wstrb; sn_araddr = araddr;
        end
    end

    // ---------------- reference model ----------------
    logic err_m = 1'b0;

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back({2'b01, a, d, s});
    endtask

    task automatic exp_rd(input logic [31:0] a);
        exp_q.push_back({2'b10, a, 32'h0, 4'h0});
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!(cfg_done && !busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, {69'd0, (k < 3000)}, 70'd1);
    endtask

    task automatic compare_log(input string tag);
        check_eq({tag, "_count"}, 70'(obs_q.size()), 70'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq({tag, "_txn"}, obs_q[i], exp_q[i]);
        check_eq({tag, "_err"}, {69'd0, err}, {69'd0, err_m});
        obs_q.delete(); exp_q.delete(); lsr_q.delete(); bresp_q.delete();
    endtask

    task automatic configure(input logic [31:0] l, input logic [31:0] f, input logic [31:0] ie,
                             input logic [1:0] e_l, input logic [1:0] e_f, input logic [1:0] e_i);
        bresp_q.push_back(e_l); bresp_q.push_back(e_f); bresp_q.push_back(e_i);
        @(negedge clk);
        cfg_lcr = l; cfg_fcr = f; cfg_ier = ie; cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        cfg_lcr = $urandom; cfg_fcr = $urandom; cfg_ier = $urandom;
        exp_wr(ADDR_LCR, l, 4'hF); exp_wr(ADDR_FCR, f, 4'hF); exp_wr(ADDR_IER, ie, 4'hF);
        err_m = (e_l != 2'b00) || (e_f != 2'b00) || (e_i != 2'b00);
        wait_idle("cfg_idle");
        compare_log("cfg");
    endtask

    task automatic send_byte(input logic [7:0] b, input int nfull, input logic rerr_ok,
                             input logic [1:0] e_tdr);
        logic [1:0] ent;
        for (int i = 0; i < nfull; i++) begin
            ent = (rerr_ok && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
            lsr_q.push_back(ent);
            if (ent[1] && i < LIMIT) err_m = 1'b1;
        end
        lsr_q.push_back(2'b00);
        bresp_q.push_back(e_tdr); bresp_q.push_back(2'b00);
        @(negedge clk);
        tx_data = b; tx_valid = 1'b1;
        check_eq("tx_ready", {69'd0, tx_ready}, 70'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0; tx_data = $urandom;
        check_eq("busy_cfgdone_sending", {68'd0, busy, cfg_done}, 70'd3);
        if (nfull >= LIMIT) begin
            for (int i = 0; i < LIMIT; i++) exp_rd(ADDR_LSR);
            err_m = 1'b1;
        end else begin
            for (int i = 0; i <= nfull; i++) exp_rd(ADDR_LSR);
            exp_wr(ADDR_TDR, {24'h0, b}, 4'h1);
`ifdef UART_SEQ_OCR_KICK_EN
            exp_wr(ADDR_OCR, 32'h2, 4'h1);
`endif
            if (e_tdr != 2'b00) err_m = 1'b1;
        end
        wait_idle("tx_idle");
        compare_log("tx");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {61'd0, awvalid, wvalid, bready, arvalid, rready,
                                 tx_ready, cfg_done, busy, err}, 70'd0);
        check_eq({tag, "_addr"}, {6'd0, awaddr, araddr}, 70'd0);
        check_eq({tag, "_data"}, {34'd0, wdata, wstrb}, 70'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_no_ready", {68'd0, tx_ready, cfg_done}, 70'd0);

        // Basic configuration
        configure(32'h3, 32'h6, 32'h1, 2'b00, 2'b00, 2'b00);
        check_eq("configured_flags", {67'd0, cfg_done, busy, tx_ready}, 70'd5);

        // Byte with TX FIFO not full, then 3 full polls, then stuck full
        send_byte(8'hA5, 0, 1'b0, 2'b00);
        send_byte(8'h3C, 3, 1'b0, 2'b00);
        send_byte(8'h77, LIMIT, 1'b0, 2'b00);
        configure($urandom, $urandom, $urandom, 2'b00, 2'b00, 2'b00);

        // SLVERR on the FCR write: sequence continues, err latched
        configure(32'h3, 32'h6, 32'h1, 2'b00, 2'b10, 2'b00);
        check_eq("cfg_done_after_err", {69'd0, cfg_done}, 70'd1);

        // cfg_start wins over a simultaneous byte
        @(negedge clk);
        cfg_lcr = 32'h11; cfg_fcr = 32'h22; cfg_ier = 32'h33;
        cfg_start = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        #1 check_eq("tx_ready_cfg_prio", {69'd0, tx_ready}, 70'd0);
        @(posedge clk);
        #1 cfg_start = 1'b0; tx_valid = 1'b0;
        exp_wr(ADDR_LCR, 32'h11, 4'hF); exp_wr(ADDR_FCR, 32'h22, 4'hF);
        exp_wr(ADDR_IER, 32'h33, 4'hF);
        err_m = 1'b0;
        wait_idle("prio_idle");
        compare_log("prio");

        // Randomised mix
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0)
                configure($urandom, $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
                          ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00,
                          ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
            else
                send_byte(8'($urandom), $urandom_range(0, 5), 1'b1,
                          ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
        end

        // Reset while the TDR write is in flight
        lsr_q.push_back(2'b00);
        @(negedge clk);
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        k = 0;
        while (!(awvalid && awaddr == ADDR_TDR) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("tdr_seen", {69'd0, (k < 500)}, 70'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete(); lsr_q.delete(); bresp_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        check_eq("post_reset_idle", {67'd0, cfg_done, busy, tx_ready}, 70'd0);
        configure(32'h3, 32'h6, 32'h1, 2'b00, 2'b00, 2'b00);
        send_byte(8'h81, 1, 1'b0, 2'b00);

        check_eq("bready_while_wvalid", 70'(bready_viol), 70'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_axil_sequencer.md
# uart_axil_sequencer

AXI4-Lite master that drives the UART register slave on behalf of a simple byte-stream source. After a configuration request it programs LCR, FCR and IER. It then accepts bytes on a valid/ready port and, for each byte:
- polls LSR until the TX FIFO is not full,
- writes the byte to TDR,
- pulses the OCR start bit.

It sits between a host-side producer (boot ROM sequencer, test harness, DMA) and the UART AXI4-Lite slave port.

## Interface
Parameters:
- TX_FULL_BIT, 1 — LSR bit index meaning "TX FIFO full".
- POLL_LIMIT, 255 — maximum consecutive LSR reads with full set before timeout; range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- cfg_start  in  1  one-cycle request to (re)program LCR/FCR/IER.
- cfg_lcr, cfg_fcr, cfg_ier  in  32 each  values written during configuration; sampled on the accepted cfg_start cycle.
- tx_data  in  8  byte to send.
- tx_valid  in  1  byte valid.
- tx_ready  out  1  byte accepted when tx_valid & tx_ready.
- cfg_done  out  1  high while configured (state READY, POLL, WR_TDR or WR_OCR).
- busy  out  1  high in every state except IDLE and READY.
- err  out  1  sticky; set on non-OKAY bresp/rresp or on poll timeout.
- m_axi_awaddr 32 out, m_axi_awvalid out, m_axi_awready in.
- m_axi_wdata 32 out, m_axi_wstrb 4 out, m_axi_wvalid out, m_axi_wready in.
- m_axi_bresp 2 in, m_axi_bvalid in, m_axi_bready out.
- m_axi_araddr 32 out, m_axi_arvalid out, m_axi_arready in.
- m_axi_rdata 32 in, m_axi_rresp 2 in, m_axi_rvalid in, m_axi_rready out.

## Operation
- Register addresses come from common_pkg (ADDR_LCR, ADDR_FCR, ADDR_IER, ADDR_LSR, ADDR_TDR, ADDR_OCR). Upper address bits are 0.
- State machine:
  - IDLE → CFG_LCR on cfg_start.
  - CFG_LCR → CFG_FCR → CFG_IER, each after its write completes.
  - CFG_IER → READY.
  - READY → POLL on byte accept.
  - POLL → WR_TDR when rdata[TX_FULL_BIT]=0.
  - POLL stays in POLL (new read) while full and count < POLL_LIMIT.
  - POLL → READY on timeout.
  - WR_TDR → WR_OCR → READY.
  - READY → CFG_LCR on cfg_start.
- Write transaction:
  - awvalid and wvalid rise together; each is held until its own handshake and dropped independently.
  - bready is asserted from issue until the bvalid handshake. The slave requires bready high while wvalid is presented.
  - A transaction completes on bvalid & bready.
- Read transaction:
  - arvalid is held until arready.
  - rready is asserted from issue until the rvalid handshake; data is captured on rvalid & rready.
- Write data and strobes:
  - Configuration writes: wdata = cfg value, wstrb = 4'hF.
  - TDR write: wdata = {24'h0, byte}, wstrb = 4'h1.
  - OCR write: wdata = 32'h2, wstrb = 4'h1.
- Byte capture: the byte is held in an internal register from accept until the TDR write completes.
- Poll counter:
  - Cleared on entry to POLL; incremented on each LSR read returning full.
  - When the count reaches POLL_LIMIT: err is set, the byte is dropped, and the FSM returns to READY.
- Error response: non-OKAY bresp/rresp sets err; the sequence continues unchanged. A failed LSR read is treated as full.
- err clears only on reset or on an accepted cfg_start.

## Timing
- Reset values:
  - state IDLE.
  - All valid/ready outputs 0.
  - awaddr, araddr, wdata, wstrb: 0.
  - tx_ready, cfg_done, busy, err: 0.
- tx_ready = (state==READY) & ~cfg_start, combinational.
  - cfg_start has priority over a simultaneous tx_valid; the byte is not accepted.
- cfg_start is ignored in CFG_*, POLL, WR_TDR and WR_OCR; it is not queued.
- Each transaction issues in the cycle after state entry; address/data registers are loaded on entry.
- The next state is entered in the cycle after the completing handshake. No back-to-back overlap: at most one outstanding transaction.
- Minimum cost per byte with a zero-wait slave: 1 accept + 2 per transaction (POLL, WR_TDR, WR_OCR) = 7 cycles.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge; the in-flight transaction is abandoned and the captured byte is lost.
- The POLL_LIMIT count is exact: err rises in the cycle the POLL_LIMIT-th full response is captured.

## Configuration
- UART_SEQ_OCR_KICK_EN defined: every TDR write is followed by the OCR start-bit write (WR_OCR state present).
- UART_SEQ_OCR_KICK_EN undefined:
  - WR_OCR and its logic are compiled out; WR_TDR → READY directly.
  - No OCR access is ever issued; minimum cost is 5 cycles per byte.

## Test plan
- Reset, then cfg_start with lcr=32'h3, fcr=32'h6, ier=32'h1 → three writes to LCR, FCR, IER in order with wstrb 4'hF; then cfg_done=1, busy=0, tx_ready=1.
- Send byte 8'hA5 with LSR full bit clear → one LSR read, TDR write of 32'hA5 with wstrb 4'h1, OCR write of 32'h2 (macro defined); then back to READY.
- LSR reports full for 3 reads, then not full → exactly 4 LSR reads before the TDR write; err stays 0.
- POLL_LIMIT=4 with LSR stuck full → 4 reads, err=1, no TDR write, READY; a following cfg_start clears err.
- Slave returns bresp=2'b10 on the FCR write → err=1; the IER write still occurs; cfg_done=1.
- cfg_start and tx_valid high together in READY → byte not accepted (tx_ready=0), reconfiguration runs; rst_n low during the TDR write → outputs at reset values next cycle, state IDLE.
